// File: rtl/vgafb_scangen.sv
// vgafb_scangen: VGA scan generator. Produces horizontal/vertical timing,
// unpacks 32-bit framebuffer words into 8/16/32 bpp pixels and writes
// {vsync, hsync, de, rgb888} words into a downstream FIFO under backpressure.

// Per-lane pixel expansion: one instance per pixel position within a word.
module vgafb_scangen_lane (
    input  logic [1:0]  mode,
    input  logic [15:0] half,
    input  logic [7:0]  grey,
    input  logic [23:0] xrgb,
    output logic [23:0] rgb
);

    // RGB565 widened by MSB replication, grey fanned out to all channels
    always_comb begin
        case (mode)
            2'd0:    rgb = {half[15:11], half[15:13],
                            half[10:5],  half[10:9],
                            half[4:0],   half[4:2]};
            2'd2:    rgb = {grey, grey, grey};
            default: rgb = xrgb;   // XRGB8888, reserved mode behaves the same
        endcase
    end

endmodule

module vgafb_scangen #(
    parameter int HBITS     = 12,
    parameter int VBITS     = 11,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             enable,
    input  logic [HBITS-1:0] hres,
    input  logic [HBITS-1:0] hsync_start,
    input  logic [HBITS-1:0] hsync_end,
    input  logic [HBITS-1:0] hscan,
    input  logic [VBITS-1:0] vres,
    input  logic [VBITS-1:0] vsync_start,
    input  logic [VBITS-1:0] vsync_end,
    input  logic [VBITS-1:0] vscan,
    input  logic [1:0]       mode,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ack,
    input  logic             out_full,
    output logic             out_we,
    output logic [26:0]      out_data,
    output logic             frame_start,
    input  logic             underrun_clr,
    output logic [15:0]      underrun_count
);

    localparam int NUM_LANES = 4;

    // Output word with both syncs at their idle level, no DE, black
    localparam logic [26:0] IDLE_WORD = {~VSYNC_POL, ~HSYNC_POL, 25'd0};

    typedef struct packed {
        logic [HBITS-1:0] hres;
        logic [HBITS-1:0] hsync_start;
        logic [HBITS-1:0] hsync_end;
        logic [HBITS-1:0] hscan;
        logic [VBITS-1:0] vres;
        logic [VBITS-1:0] vsync_start;
        logic [VBITS-1:0] vsync_end;
        logic [VBITS-1:0] vscan;
        logic [1:0]       mode;
    } timing_t;

    timing_t          tin;
    timing_t          ts;
    logic [HBITS-1:0] h;
    logic [VBITS-1:0] v;
    logic [1:0]       lane;
    logic [1:0]       last_lane;

    logic [NUM_LANES-1:0][23:0] lane_rgb;
    logic [23:0]      pix;

    logic active;
    logic hs_on;
    logic vs_on;
    logic hs_lvl;
    logic vs_lvl;
    logic line_end;
    logic frame_end;
    logic word_done;
    logic step;
    logic stall;

    assign tin = {hres, hsync_start, hsync_end, hscan,
                  vres, vsync_start, vsync_end, vscan, mode};

    // Number of pixels per framebuffer word for the latched mode, minus one
    always_comb begin
        case (ts.mode)
            2'd0:    last_lane = 2'd1;
            2'd2:    last_lane = 2'd3;
            default: last_lane = 2'd0;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        vgafb_scangen_lane u_lane (
            .mode (ts.mode),
            .half (in_data[31-16*(i%2) -: 16]),
            .grey (in_data[31-8*i -: 8]),
            .xrgb (in_data[23:0]),
            .rgb  (lane_rgb[i])
        );
    end

    assign active    = (h < ts.hres) && (v < ts.vres);
    assign hs_on     = (h >= ts.hsync_start) && (h < ts.hsync_end);
    assign vs_on     = (v >= ts.vsync_start) && (v < ts.vsync_end);
    assign hs_lvl    = hs_on ? HSYNC_POL : ~HSYNC_POL;
    assign vs_lvl    = vs_on ? VSYNC_POL : ~VSYNC_POL;
    assign line_end  = (h == ts.hscan);
    assign frame_end = line_end && (v == ts.vscan);

    // A word is finished when its last lane is used or the line runs out;
    // any lanes left over at the end of a line are simply dropped.
    assign word_done = (lane == last_lane) || (h == ts.hres - HBITS'(1));

    assign step   = enable & ~out_full & (~active | in_valid);
    assign stall  = enable & active & ~in_valid & ~out_full;
    assign in_ack = step & active & word_done;
    assign pix    = active ? lane_rgb[lane] : 24'd0;

    // Timing shadows: track inputs while idle, otherwise only at frame wrap
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            ts <= '0;
        else if (!enable || (step && frame_end))
            ts <= tin;
    end

    // Raster position and lane pointer
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            h    <= '0;
            v    <= '0;
            lane <= '0;
        end else if (!enable) begin
            h    <= '0;
            v    <= '0;
            lane <= '0;
        end else if (step) begin
            if (active)
                lane <= in_ack ? 2'd0 : lane + 2'd1;
            if (line_end) begin
                h <= '0;
                v <= (v == ts.vscan) ? '0 : v + VBITS'(1);
            end else begin
                h <= h + HBITS'(1);
            end
        end
    end

    // Output word, write strobe and frame marker, one cycle after the step
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_we      <= 1'b0;
            out_data    <= IDLE_WORD;
            frame_start <= 1'b0;
        end else begin
            out_we      <= step;
            frame_start <= step && (h == '0) && (v == '0);
            if (!enable)
                out_data <= IDLE_WORD;
            else if (step)
                out_data <= {vs_lvl, hs_lvl, active, pix};
        end
    end

    // Saturating underrun counter; clear wins over a simultaneous stall
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            underrun_count <= '0;
        else if (underrun_clr)
            underrun_count <= '0;
        else if (stall && (underrun_count != 16'hFFFF))
            underrun_count <= underrun_count + 16'd1;
    end

endmodule

// File: tb/tb_vgafb_scangen.sv
// Directed bench for vgafb_scangen: table-driven line checks plus
// hand-written sequences for backpressure, underrun, shadowing, enable,
// inverted sync polarity and asynchronous reset.
module tb_vgafb_scangen;

    logic        sys_clk;
    logic        sys_rst;
    logic        enable;
    logic [11:0] hres, hsync_start, hsync_end, hscan;
    logic [10:0] vres, vsync_start, vsync_end, vscan;
    logic [1:0]  mode;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ack, in_ack2;
    logic        out_full;
    logic        out_we, out_we2;
    logic [26:0] out_data, out_data2;
    logic        frame_start, frame_start2;
    logic        underrun_clr;
    logic [15:0] underrun_count, underrun_count2;

    vgafb_scangen #(.HBITS(12), .VBITS(11), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
        .hres(hres), .hsync_start(hsync_start), .hsync_end(hsync_end), .hscan(hscan),
        .vres(vres), .vsync_start(vsync_start), .vsync_end(vsync_end), .vscan(vscan),
        .mode(mode), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
        .out_full(out_full), .out_we(out_we), .out_data(out_data),
        .frame_start(frame_start), .underrun_clr(underrun_clr),
        .underrun_count(underrun_count)
    );

    vgafb_scangen #(.HBITS(12), .VBITS(11), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
        .hres(hres), .hsync_start(hsync_start), .hsync_end(hsync_end), .hscan(hscan),
        .vres(vres), .vsync_start(vsync_start), .vsync_end(vsync_end), .vscan(vscan),
        .mode(mode), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack2),
        .out_full(out_full), .out_we(out_we2), .out_data(out_data2),
        .frame_start(frame_start2), .underrun_clr(underrun_clr),
        .underrun_count(underrun_count2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        en, vld, full, clr;
        logic        ack, we, fs;
        logic [26:0] data;
    } vec_t;

    localparam logic [26:0] FULL = 27'h7FFFFFF;
    localparam logic [26:0] SYNC = 27'h7000000;
    localparam logic [26:0] IDLE = 27'h6000000;

    int          n_chk;
    int          n_fail;
    logic [31:0] words[4];
    int          nwords;
    int          widx;
    vec_t        t1[8];
    vec_t        t2[9];
    logic [23:0] rgb_l[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check combinational ack, then registered outputs
    task automatic cyc(input logic en, input logic vld, input logic full, input logic clr,
                       input logic e_ack, input logic e_we, input logic e_fs,
                       input logic [26:0] e_data, input logic [26:0] mask, input string name);
        logic ack_s;
        enable = en; in_valid = vld; out_full = full; underrun_clr = clr;
        in_data = words[widx % nwords];
        #1;
        ack_s = in_ack;
        chk({name, " ack"}, {31'd0, ack_s}, {31'd0, e_ack});
        @(posedge sys_clk);
        if (ack_s) widx++;
        #1;
        chk({name, " we"}, {31'd0, out_we}, {31'd0, e_we});
        chk({name, " fs"}, {31'd0, frame_start}, {31'd0, e_fs});
        if (mask != 27'd0)
            chk({name, " data"}, {5'd0, out_data & mask}, {5'd0, e_data & mask});
    endtask

    task automatic cfg(input logic [11:0] hr, input logic [11:0] hs0, input logic [11:0] hs1,
                       input logic [11:0] hsc, input logic [10:0] vr, input logic [1:0] md,
                       input string name);
        hres = hr; hsync_start = hs0; hsync_end = hs1; hscan = hsc;
        vres = vr; vsync_start = 11'd2; vsync_end = 11'd3; vscan = 11'd3; mode = md;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, FULL, name);
        widx = 0;
    endtask

    initial begin
        int hp, vp;
        logic act;
        n_chk = 0; n_fail = 0; widx = 0; nwords = 2;
        words[0] = 32'hF800001F; words[1] = 32'h07E0FFFF;
        words[2] = 32'h0; words[3] = 32'h0;
        rgb_l[0] = 24'hFF0000; rgb_l[1] = 24'h0000FF;
        rgb_l[2] = 24'h00FF00; rgb_l[3] = 24'hFFFFFF;

        // Line 0 of the RGB565 frame: {en,vld,full,clr, ack,we,fs, data}
        t1[0] = '{1, 1, 0, 0, 0, 1, 1, {3'b111, 24'hFF0000}};
        t1[1] = '{1, 1, 0, 0, 1, 1, 0, {3'b111, 24'h0000FF}};
        t1[2] = '{1, 1, 0, 0, 0, 1, 0, {3'b111, 24'h00FF00}};
        t1[3] = '{1, 1, 0, 0, 1, 1, 0, {3'b111, 24'hFFFFFF}};
        t1[4] = '{1, 1, 0, 0, 0, 1, 0, {3'b110, 24'h000000}};
        t1[5] = '{1, 1, 0, 0, 0, 1, 0, {3'b100, 24'h000000}};
        t1[6] = '{1, 1, 0, 0, 0, 1, 0, {3'b110, 24'h000000}};
        t1[7] = '{1, 1, 0, 0, 0, 1, 0, {3'b110, 24'h000000}};
        // Grey mode, 3 active pixels, fourth byte dropped, next line new word
        t2[0] = '{1, 1, 0, 0, 0, 1, 1, {3'b111, 24'h111111}};
        t2[1] = '{1, 1, 0, 0, 0, 1, 0, {3'b111, 24'h222222}};
        t2[2] = '{1, 1, 0, 0, 1, 1, 0, {3'b111, 24'h333333}};
        t2[3] = '{1, 1, 0, 0, 0, 1, 0, {3'b110, 24'h000000}};
        t2[4] = '{1, 1, 0, 0, 0, 1, 0, {3'b110, 24'h000000}};
        t2[5] = '{1, 1, 0, 0, 0, 1, 0, {3'b100, 24'h000000}};
        t2[6] = '{1, 1, 0, 0, 0, 1, 0, {3'b110, 24'h000000}};
        t2[7] = '{1, 1, 0, 0, 0, 1, 0, {3'b110, 24'h000000}};
        t2[8] = '{1, 1, 0, 0, 0, 1, 0, {3'b111, 24'h555555}};

        // Reset state
        sys_rst = 1'b1; enable = 1'b0; in_valid = 1'b0; out_full = 1'b0;
        underrun_clr = 1'b0; in_data = '0; mode = '0;
        hres = '0; hsync_start = '0; hsync_end = '0; hscan = '0;
        vres = '0; vsync_start = '0; vsync_end = '0; vscan = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst we", {31'd0, out_we}, 32'd0);
        chk("rst data", {5'd0, out_data}, {5'd0, IDLE});
        chk("rst data pol1", {5'd0, out_data2}, 32'd0);
        chk("rst fs", {31'd0, frame_start}, 32'd0);
        chk("rst underrun", {16'd0, underrun_count}, 32'd0);
        sys_rst = 1'b0;

        // RGB565 frame: table for line 0, then a position model for two frames
        cfg(12'd4, 12'd5, 12'd6, 12'd7, 11'd2, 2'd0, "t1 cfg");
        for (int i = 0; i < 8; i++)
            cyc(t1[i].en, t1[i].vld, t1[i].full, t1[i].clr, t1[i].ack, t1[i].we,
                t1[i].fs, t1[i].data, FULL, $sformatf("t1[%0d]", i));
        for (int s = 8; s < 64; s++) begin
            hp = s % 8; vp = (s / 8) % 4;
            act = (hp < 4) && (vp < 2);
            cyc(1, 1, 0, 0, act && (hp == 1 || hp == 3), 1, (s % 32) == 0,
                {(vp == 2) ? 1'b0 : 1'b1, (hp == 5) ? 1'b0 : 1'b1, act,
                 act ? rgb_l[hp] : 24'h0}, FULL, $sformatf("t1 s%0d", s));
        end

        // Grey mode with leftover lane
        words[0] = 32'h11223344; words[1] = 32'h55667788;
        cfg(12'd3, 12'd5, 12'd6, 12'd7, 11'd2, 2'd2, "t2 cfg");
        for (int i = 0; i < 9; i++)
            cyc(t2[i].en, t2[i].vld, t2[i].full, t2[i].clr, t2[i].ack, t2[i].we,
                t2[i].fs, t2[i].data, FULL, $sformatf("t2[%0d]", i));

        // FIFO full mid-line freezes the scan
        words[0] = 32'hF800001F; words[1] = 32'h07E0FFFF;
        cfg(12'd4, 12'd5, 12'd6, 12'd7, 11'd2, 2'd0, "t3 cfg");
        cyc(1, 1, 0, 0, 0, 1, 1, {3'b111, 24'hFF0000}, FULL, "t3 h0");
        for (int i = 0; i < 5; i++)
            cyc(1, 1, 1, 0, 0, 0, 0, 27'd0, 27'd0, $sformatf("t3 full%0d", i));
        chk("t3 underrun", {16'd0, underrun_count}, 32'd0);
        cyc(1, 1, 0, 0, 1, 1, 0, {3'b111, 24'h0000FF}, FULL, "t3 h1");

        // Underrun: 10 stalls, then saturation, then clear beats increment
        for (int i = 0; i < 10; i++)
            cyc(1, 0, 0, 0, 0, 0, 0, 27'd0, 27'd0, $sformatf("t4 stall%0d", i));
        chk("t4 underrun10", {16'd0, underrun_count}, 32'd10);
        cyc(1, 1, 0, 0, 0, 1, 0, {3'b111, 24'h00FF00}, FULL, "t4 h2");
        enable = 1'b1; in_valid = 1'b0; out_full = 1'b0; underrun_clr = 1'b0;
        repeat (70000) @(posedge sys_clk);
        #1;
        chk("t4 underrun sat", {16'd0, underrun_count}, 32'h0000FFFF);
        cyc(1, 0, 0, 1, 0, 0, 0, 27'd0, 27'd0, "t4 clr");
        chk("t4 underrun clr", {16'd0, underrun_count}, 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 27'd0, 27'd0, "t4 recount");
        chk("t4 underrun 1", {16'd0, underrun_count}, 32'd1);

        // Mid-frame geometry/mode change waits for the frame wrap
        words[0] = 32'hAABBCCDD; nwords = 1;
        cfg(12'd4, 12'd5, 12'd6, 12'd7, 11'd2, 2'd0, "t5 cfg");
        for (int s = 0; s < 32; s++) begin
            if (s == 10) begin
                hres = 12'd2; mode = 2'd2;
            end
            hp = s % 8; vp = s / 8;
            act = (hp < 4) && (vp < 2);
            cyc(1, 1, 0, 0, act && (hp == 1 || hp == 3), 1, s == 0,
                {(vp == 2) ? 1'b0 : 1'b1, (hp == 5) ? 1'b0 : 1'b1, act, 24'h0},
                SYNC, $sformatf("t5 old s%0d", s));
        end
        cyc(1, 1, 0, 0, 0, 1, 1, {3'b111, 24'hAAAAAA}, FULL, "t5 new h0");
        cyc(1, 1, 0, 0, 1, 1, 0, {3'b111, 24'hBBBBBB}, FULL, "t5 new h1");
        cyc(1, 1, 0, 0, 0, 1, 0, {3'b110, 24'h000000}, FULL, "t5 new h2");

        // Empty frame (hres=0) and empty hsync window
        cfg(12'd0, 12'd6, 12'd5, 12'd7, 11'd2, 2'd0, "t7 cfg");
        for (int s = 0; s < 32; s++) begin
            vp = s / 8;
            cyc(1, 1, 0, 0, 0, 1, s == 0,
                {(vp == 2) ? 1'b0 : 1'b1, 1'b1, 1'b0, 24'h0}, FULL, $sformatf("t7 s%0d", s));
        end

        // Inverted polarity build, enable drop mid-line, async reset mid-frame
        words[0] = 32'hF800001F; words[1] = 32'h07E0FFFF; nwords = 2;
        cfg(12'd4, 12'd5, 12'd6, 12'd7, 11'd2, 2'd0, "t6 cfg");
        chk("t6 idle pol1", {5'd0, out_data2}, 32'd0);
        cyc(1, 1, 0, 0, 0, 1, 1, {3'b111, 24'hFF0000}, FULL, "t6 h0");
        chk("t6 h0 pol1", {5'd0, out_data2}, {5'd0, 3'b001, 24'hFF0000});
        cyc(1, 1, 0, 0, 1, 1, 0, {3'b111, 24'h0000FF}, FULL, "t6 h1");
        cyc(1, 1, 0, 0, 0, 1, 0, {3'b111, 24'h00FF00}, FULL, "t6 h2");
        cyc(0, 1, 0, 0, 0, 0, 0, IDLE, FULL, "t6 disable");
        chk("t6 disable pol1", {5'd0, out_data2}, 32'd0);
        chk("t6 disable we2", {31'd0, out_we2}, 32'd0);
        widx = 0;
        cyc(1, 1, 0, 0, 0, 1, 1, {3'b111, 24'hFF0000}, FULL, "t6 resume h0");
        chk("t6 resume pol1", {5'd0, out_data2}, {5'd0, 3'b001, 24'hFF0000});
        cyc(1, 1, 0, 0, 1, 1, 0, {3'b111, 24'h0000FF}, FULL, "t6 resume h1");
        cyc(1, 1, 0, 0, 0, 1, 0, {3'b111, 24'h00FF00}, FULL, "t6 resume h2");
        cyc(1, 1, 0, 0, 1, 1, 0, {3'b111, 24'hFFFFFF}, FULL, "t6 resume h3");
        cyc(1, 1, 0, 0, 0, 1, 0, {3'b110, 24'h000000}, FULL, "t6 resume h4");
        chk("t6 h4 pol1", {5'd0, out_data2}, 32'd0);
        cyc(1, 1, 0, 0, 0, 1, 0, {3'b100, 24'h000000}, FULL, "t6 resume h5");
        chk("t6 h5 pol1", {5'd0, out_data2}, {5'd0, 3'b010, 24'h0});
        sys_rst = 1'b1;
        #1;
        chk("t6 arst we", {31'd0, out_we}, 32'd0);
        chk("t6 arst data", {5'd0, out_data}, {5'd0, IDLE});
        chk("t6 arst data pol1", {5'd0, out_data2}, 32'd0);
        chk("t6 arst fs", {31'd0, frame_start}, 32'd0);
        chk("t6 arst ack", {31'd0, in_ack}, 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        cfg(12'd4, 12'd5, 12'd6, 12'd7, 11'd2, 2'd0, "t6 post-rst cfg");
        cyc(1, 1, 0, 0, 0, 1, 1, {3'b111, 24'hFF0000}, FULL, "t6 post-rst h0");
        chk("t6 post-rst pol1", {5'd0, out_data2}, {5'd0, 3'b001, 24'hFF0000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
